// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the MAC sequencer: FSM states, issue tag, width functions.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Tag address field is sized for the largest supported matrix; users slice to AW.
  localparam int MAX_AW = 16;

  typedef struct packed {
    logic              valid;
    logic              first;
    logic              last;
    logic [MAX_AW-1:0] c_addr;
  } tag_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int calc_aw(input int size);
    return clog2_min1(size * size);
  endfunction

  function automatic int calc_iw(input int size);
    return clog2_min1(size);
  endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Start/done handshake plus operand-read, MAC-control and result-write strobes of the sequencer.
interface mac_sequencer_if #(parameter int AW = 4);
  logic          start;
  logic          hold;
  logic          busy;
  logic          done;
  logic          a_rd_en;
  logic [AW-1:0] a_rd_addr;
  logic          b_rd_en;
  logic [AW-1:0] b_rd_addr;
  logic          mac_en;
  logic          mac_clr;
  logic          mac_last;
  logic          c_wr_en;
  logic [AW-1:0] c_wr_addr;

  modport master (
    output start, hold,
    input  busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
    input  mac_en, mac_clr, mac_last, c_wr_en, c_wr_addr
  );

  modport slave (
    input  start, hold,
    output busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
    output mac_en, mac_clr, mac_last, c_wr_en, c_wr_addr
  );
endinterface

// File: rtl/mac_tag_delay.sv
// Fixed-depth shift register for issue tags, synchronous active-low clear.
module mac_tag_delay
  import mac_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_t din,
  output tag_t dout
);

  tag_t pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < DEPTH; s++) pipe[s] <= '0;
    end else begin
      pipe[0] <= din;
      for (int s = 1; s < DEPTH; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/mac_sequencer.sv
// Sequences the MAC datapath through C = A x B: walks i/j/k, issues operand reads, tags MAC
// terms first/last and issues the C write when each dot product leaves the pipe.
//
//   state    | meaning
//   ST_IDLE  | waiting for start, indices parked at zero
//   ST_RUN   | one operand read per unheld cycle, k innermost
//   ST_DRAIN | all reads issued, waiting for the final C write
//   ST_DONE  | single-cycle done pulse, then back to idle
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int SIZE    = 4,
  parameter int MEM_LAT = 1,
  parameter int MAC_LAT = 2,
  parameter int AW      = calc_aw(SIZE)
) (
  input logic            clk,
  input logic            reset,
  mac_sequencer_if.slave bus
);

  localparam int                IW      = calc_iw(SIZE);
  localparam logic [IW-1:0]     IDX_MAX = IW'(SIZE - 1);
  localparam logic [MAX_AW-1:0] LAST_C  = MAX_AW'(SIZE * SIZE - 1);

  state_t        state, state_nx;
  logic [IW-1:0] i_idx, j_idx, k_idx;
  logic          issue, k_wrap, j_wrap, i_wrap, last_issue, last_wr;
  tag_t          issue_tag, mac_tag, wr_in_tag, wr_tag;
  logic          unused_tag;

  assign issue      = (state == ST_RUN) && !bus.hold;
  assign k_wrap     = (k_idx == IDX_MAX);
  assign j_wrap     = (j_idx == IDX_MAX);
  assign i_wrap     = (i_idx == IDX_MAX);
  assign last_issue = issue && k_wrap && j_wrap && i_wrap;
  // Writes leave in address order, so the final C address marks the end of the drain.
  assign last_wr    = wr_tag.valid && (wr_tag.c_addr == LAST_C);

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (bus.start) state_nx = ST_RUN;
      ST_RUN:   if (last_issue) state_nx = ST_DRAIN;
      ST_DRAIN: if (last_wr) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || state == ST_IDLE) begin
      i_idx <= '0;
      j_idx <= '0;
      k_idx <= '0;
    end else if (issue) begin
      if (k_wrap) begin
        k_idx <= '0;
        if (j_wrap) begin
          j_idx <= '0;
          i_idx <= i_wrap ? '0 : i_idx + IW'(1);
        end else begin
          j_idx <= j_idx + IW'(1);
        end
      end else begin
        k_idx <= k_idx + IW'(1);
      end
    end
  end

  always_comb begin
    issue_tag = '0;
    if (issue) begin
      issue_tag.valid  = 1'b1;
      issue_tag.first  = (k_idx == '0);
      issue_tag.last   = k_wrap;
      issue_tag.c_addr = MAX_AW'(int'(i_idx) * SIZE + int'(j_idx));
    end
  end

  mac_tag_delay #(.DEPTH(MEM_LAT)) u_mem_dly (
    .clk  (clk),
    .reset(reset),
    .din  (issue_tag),
    .dout (mac_tag)
  );

  // Only the closing term of a dot product travels on to the write stage.
  always_comb begin
    wr_in_tag       = mac_tag;
    wr_in_tag.valid = mac_tag.valid && mac_tag.last;
  end

  mac_tag_delay #(.DEPTH(MAC_LAT)) u_mac_dly (
    .clk  (clk),
    .reset(reset),
    .din  (wr_in_tag),
    .dout (wr_tag)
  );

  assign unused_tag = ^{wr_tag.first, wr_tag.last};

  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.a_rd_en   = issue;
  assign bus.b_rd_en   = issue;
  assign bus.a_rd_addr = AW'(int'(i_idx) * SIZE + int'(k_idx));
  assign bus.b_rd_addr = AW'(int'(k_idx) * SIZE + int'(j_idx));
  assign bus.mac_en    = mac_tag.valid;
  assign bus.mac_clr   = mac_tag.valid && mac_tag.first;
  assign bus.mac_last  = mac_tag.valid && mac_tag.last;
  assign bus.c_wr_en   = wr_tag.valid;
  assign bus.c_wr_addr = wr_tag.c_addr[AW-1:0];

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer at SIZE 4, 3 and 1: cycle-exact schedule model, operand memories
// and a behavioural MAC that rebuilds C for comparison against a plain matrix product.
module tb_mac_sequencer;
  import mac_pkg::*;

  localparam int ML   = 1;
  localparam int CL   = 2;
  localparam int MAXC = 256;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_a;
    logic       rd_b;
    logic [7:0] a_addr;
    logic [7:0] b_addr;
    logic       mac_en;
    logic       clr;
    logic       last;
    logic       wr;
    logic [7:0] c_addr;
  } obs_t;

  typedef struct {
    int d;
    int hs;
    int hl;
    int exp_done;
    int exp_wr;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [2:0] start_v = '0;
  logic [2:0] hold_v = '0;
  int sz[3] = '{4, 3, 1};

  mac_sequencer_if #(.AW(4)) bus4 ();
  mac_sequencer_if #(.AW(4)) bus3 ();
  mac_sequencer_if #(.AW(1)) bus1 ();

  assign bus4.start = start_v[0];
  assign bus4.hold  = hold_v[0];
  assign bus3.start = start_v[1];
  assign bus3.hold  = hold_v[1];
  assign bus1.start = start_v[2];
  assign bus1.hold  = hold_v[2];

  mac_sequencer #(.SIZE(4)) u_s4 (.clk(clk), .reset(reset), .bus(bus4));
  mac_sequencer #(.SIZE(3)) u_s3 (.clk(clk), .reset(reset), .bus(bus3));
  mac_sequencer #(.SIZE(1)) u_s1 (.clk(clk), .reset(reset), .bus(bus1));

  obs_t obs[3];
  assign obs[0] = {bus4.busy, bus4.done, bus4.a_rd_en, bus4.b_rd_en, 8'(bus4.a_rd_addr),
                   8'(bus4.b_rd_addr), bus4.mac_en, bus4.mac_clr, bus4.mac_last, bus4.c_wr_en,
                   8'(bus4.c_wr_addr)};
  assign obs[1] = {bus3.busy, bus3.done, bus3.a_rd_en, bus3.b_rd_en, 8'(bus3.a_rd_addr),
                   8'(bus3.b_rd_addr), bus3.mac_en, bus3.mac_clr, bus3.mac_last, bus3.c_wr_en,
                   8'(bus3.c_wr_addr)};
  assign obs[2] = {bus1.busy, bus1.done, bus1.a_rd_en, bus1.b_rd_en, 8'(bus1.a_rd_addr),
                   8'(bus1.b_rd_addr), bus1.mac_en, bus1.mac_clr, bus1.mac_last, bus1.c_wr_en,
                   8'(bus1.c_wr_addr)};

  // Operand memories and behavioural MAC attached to the DUT selected by cur.
  int   cur = 0;
  obs_t cur_o;
  assign cur_o = obs[cur];

  int   A_m[16];
  int   B_m[16];
  int   C_m[16];
  int   q[$];
  int   acc = 0;
  int   op_a = 0;
  int   op_b = 0;
  int   orphan = 0;
  logic clr_req = 1'b0;

  function automatic int fold(input int a, input int p, input logic clr);
    return clr ? p : a + p;
  endfunction

  always @(posedge clk) begin
    if (clr_req) for (int n = 0; n < 16; n++) C_m[n] <= -1;
    if (!reset) begin
      q.delete();
      acc <= 0;
    end else begin
      if (cur_o.rd_a) begin
        op_a <= A_m[cur_o.a_addr[3:0]];
        op_b <= B_m[cur_o.b_addr[3:0]];
      end
      if (cur_o.mac_en) begin
        acc <= fold(acc, op_a * op_b, cur_o.clr);
        if (cur_o.last) q.push_back(fold(acc, op_a * op_b, cur_o.clr));
      end
      if (cur_o.wr) begin
        if (q.size() == 0) orphan <= orphan + 1;
        else begin
          if (cur_o.c_addr < 16) C_m[cur_o.c_addr[3:0]] <= q[0];
          void'(q.pop_front());
        end
      end
    end
  end

  logic hpat[MAXC];
  obs_t e_tab[MAXC];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_obs(input int t, input obs_t act, input obs_t exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL cycle%0d outputs: got %h expected %h", t, act, exp);
    end
  endtask

  task automatic load_mats(input int d, input bit rnd);
    int s;
    s = sz[d];
    for (int n = 0; n < 16; n++) begin
      A_m[n] = 0;
      B_m[n] = 0;
    end
    for (int r = 0; r < s; r++)
      for (int c = 0; c < s; c++) begin
        A_m[r*s+c] = rnd ? int'($urandom_range(0, 15)) : ((r == c) ? 1 : 0);
        B_m[r*s+c] = rnd ? int'($urandom_range(0, 15)) : r * s + c + 1;
      end
  endtask

  task automatic clear_hold();
    for (int t = 0; t < MAXC; t++) hpat[t] = 1'b0;
  endtask

  // Expected schedule: n-th unheld RUN cycle issues term n of the i,j,k walk; MAC and write
  // events follow at fixed latencies. Entered and left at #1 after a rising edge.
  task automatic run_check(input int d, output int done_c, output int wr_n);
    int s, n, c, dexp, i, j, k, o0, cbad, exp_c;
    obs_t act, ex;
    s = sz[d];
    for (int t = 0; t < MAXC; t++) e_tab[t] = '0;
    n = 0;
    c = 0;
    dexp = 0;
    while (n < s * s * s && c < MAXC - 8) begin
      if (!hpat[c]) begin
        i = n / (s * s);
        j = (n / s) % s;
        k = n % s;
        e_tab[c].rd_a = 1'b1;
        e_tab[c].rd_b = 1'b1;
        e_tab[c].a_addr = 8'(i * s + k);
        e_tab[c].b_addr = 8'(k * s + j);
        e_tab[c+ML].mac_en = 1'b1;
        e_tab[c+ML].clr = (k == 0);
        e_tab[c+ML].last = (k == s - 1);
        if (k == s - 1) begin
          e_tab[c+ML+CL].wr = 1'b1;
          e_tab[c+ML+CL].c_addr = 8'(i * s + j);
          dexp = c + ML + CL + 1;
        end
        n++;
      end
      c++;
    end
    e_tab[dexp].done = 1'b1;
    for (int t = 0; t <= dexp; t++) e_tab[t].busy = 1'b1;

    cur = d;
    clr_req = 1'b1;
    @(posedge clk);
    #1 clr_req = 1'b0;
    start_v[d] = 1'b1;
    @(posedge clk);
    #1 start_v[d] = 1'b0;
    o0 = orphan;
    done_c = -1;
    wr_n = 0;
    for (int t = 0; t <= dexp + 2; t++) begin
      hold_v[d] = hpat[t];
      @(negedge clk);
      act = obs[d];
      ex = e_tab[t];
      if (!ex.rd_a) begin
        act.a_addr = '0;
        act.b_addr = '0;
      end
      if (!ex.mac_en) begin
        act.clr = 1'b0;
        act.last = 1'b0;
      end
      if (!ex.wr) act.c_addr = '0;
      if (act.done && done_c < 0) done_c = t;
      if (act.wr) wr_n++;
      check_obs(t, act, ex);
      @(posedge clk);
      #1;
    end
    hold_v[d] = 1'b0;
    check("done_cycle", done_c, dexp);
    check("orphan_writes", orphan - o0, 0);
    cbad = 0;
    for (int r = 0; r < s; r++)
      for (int cc = 0; cc < s; cc++) begin
        exp_c = 0;
        for (int kk = 0; kk < s; kk++) exp_c += A_m[r*s+kk] * B_m[kk*s+cc];
        if (C_m[r*s+cc] != exp_c) begin
          if (cbad == 0)
            $display("FAIL c_matrix[%0d]: got %0d expected %0d", r * s + cc, C_m[r*s+cc], exp_c);
          cbad++;
        end
      end
    check("c_matrix_errors", cbad, 0);
  endtask

  vec_t tbl[7];
  int dc, wn, quiet, dn, d1, d2, berr;
  bit exp_b;

  initial begin
    tbl[0] = '{d: 0, hs: 0,  hl: 0, exp_done: 67, exp_wr: 16};
    tbl[1] = '{d: 0, hs: 10, hl: 5, exp_done: 72, exp_wr: 16};
    tbl[2] = '{d: 1, hs: 0,  hl: 0, exp_done: 30, exp_wr: 9};
    tbl[3] = '{d: 2, hs: 0,  hl: 0, exp_done: 4,  exp_wr: 1};
    tbl[4] = '{d: 1, hs: 3,  hl: 2, exp_done: 32, exp_wr: 9};
    tbl[5] = '{d: 2, hs: 0,  hl: 3, exp_done: 7,  exp_wr: 1};
    tbl[6] = '{d: 0, hs: 63, hl: 2, exp_done: 69, exp_wr: 16};

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("reset_outputs%0d", d), int'(obs[d]), 0);
    @(posedge clk);
    #1;

    for (int v = 0; v < 7; v++) begin
      clear_hold();
      for (int t = tbl[v].hs; t < tbl[v].hs + tbl[v].hl; t++) hpat[t] = 1'b1;
      load_mats(tbl[v].d, 1'b0);
      run_check(tbl[v].d, dc, wn);
      check($sformatf("tbl%0d_done", v), dc, tbl[v].exp_done);
      check($sformatf("tbl%0d_writes", v), wn, tbl[v].exp_wr);
    end

    // Reset in the middle of a run: outputs clear, nothing further, then a clean restart.
    clear_hold();
    load_mats(0, 1'b0);
    cur = 0;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", int'(obs[0]), 0);
    quiet = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (obs[0].busy || obs[0].done || obs[0].rd_a || obs[0].mac_en || obs[0].wr) quiet++;
    end
    check("abort_quiet", quiet, 0);
    @(posedge clk);
    #1;
    run_check(0, dc, wn);
    check("restart_done", dc, 67);

    // start held high: one run per IDLE entry, idle for one cycle between runs.
    clear_hold();
    load_mats(0, 1'b0);
    cur = 0;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    dn = 0;
    d1 = -1;
    d2 = -1;
    berr = 0;
    for (int t = 0; t <= 150; t++) begin
      if (t == 100) start_v[0] = 1'b0;
      @(negedge clk);
      if (obs[0].done) begin
        dn++;
        if (d1 < 0) d1 = t;
        else if (d2 < 0) d2 = t;
      end
      exp_b = !(t == 68 || t >= 137);
      if (obs[0].busy != exp_b) berr++;
      @(posedge clk);
      #1;
    end
    check("held_start_done_count", dn, 2);
    check("held_start_done1", d1, 67);
    check("held_start_done2", d2, 136);
    check("held_start_busy_errors", berr, 0);

    // Random hold patterns and random operands on every size.
    for (int r = 0; r < 6; r++) begin
      clear_hold();
      for (int t = 0; t < 120; t++) hpat[t] = ($urandom_range(0, 3) == 0);
      load_mats(r % 3, 1'b1);
      run_check(r % 3, dc, wn);
      check($sformatf("rand%0d_writes", r), wn, sz[r%3] * sz[r%3]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
